jtag_scan_master: RTL
=====================

# jtag_scan_master

Host-side JTAG scan engine: the initiator for a 2-bit-IR virtual-JTAG debug responder on the Nios debug path. It accepts IR-scan or DR-scan commands from a system-clock controller, generates TCK/TMS/TDI by clock division, walks the TAP state machine from Run-Test/Idle and back, and returns captured TDO bits. It sits between a debug controller (UK101 monitor or test harness) and the JTAG pins of a target TAP on the DE0-CV.

## Interface
- DATA_W, 38: maximum scan length in bits.
- CLK_DIV, 4: clk cycles per TCK half-period; must be ≥1. At 50 MHz, 4 gives 6.25 MHz TCK.
- LEN_W, $clog2(DATA_W+1): width of cmd_len.

- clk  in  1  system clock; the block's only clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both are high.
- cmd_op  in  2  00 = DR scan, 01 = IR scan, 10 = TAP reset, 11 = reserved.
- cmd_len  in  LEN_W  bits to shift, 1..DATA_W.
- cmd_data  in  DATA_W  TDI bits, LSB shifted first.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when both are high.
- rsp_data  out  DATA_W  captured TDO; first bit in [0], bits ≥ len are zero.
- rsp_err  out  1  command rejected; no TCK was issued.
- jtag_tck  out  1  test clock.
- jtag_tms  out  1  test mode select.
- jtag_tdi  out  1  test data in.
- jtag_tdo  in  1  test data out from the target.

## Operation
- FSM states: INIT_TLR, IDLE, SCAN, RESP.
- INIT_TLR: entered on reset. Issues 5 TCKs with TMS=1, then 1 TCK with TMS=0. The TAP ends in Run-Test/Idle. cmd_ready is low throughout.
- IDLE: cmd_ready=1 only when no response is pending.
- SCAN drives a TMS sequence from Run-Test/Idle:
  - DR scan: TMS 1,0,0; then len shift TCKs with TMS=0 except the last, which has TMS=1; then TMS 1,0. Total TCK count T = len+5.
  - IR scan: same as DR scan with one extra leading TMS=1. T = len+6.
- TDI carries cmd_data[i] during shift TCK i. TDI is 0 outside the shift TCKs.
- TDO is sampled only on shift TCKs and stored into rsp_data[i].
- Length 0, length > DATA_W, or op 11: no TCK is issued. The block goes straight to RESP with rsp_err=1 and rsp_data=0.
- RESP holds rsp_valid, rsp_data and rsp_err stable until rsp_ready. The block then returns to IDLE.
- Reset mid-scan:
  - All outputs take their reset values at the next edge.
  - The partial result is discarded.
  - INIT_TLR re-synchronises the TAP.

## Timing
- Reset values: jtag_tck=0, jtag_tms=1, jtag_tdi=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0.
- The accept edge E registers TMS/TDI for TCK 0 and starts its low phase.
- TCK k: low in [E+2k·CLK_DIV, E+(2k+1)·CLK_DIV); high for the next CLK_DIV cycles.
- TMS/TDI change only on edges where TCK falls, or at E.
- TDO is sampled on the edge where TCK rises.
- Final TCK falls at E+2T·CLK_DIV. rsp_valid rises on that same edge.
- Scan latency is 2T·CLK_DIV clks. A rejected command gives rsp_valid at E+1.
- Back-to-back commands: the earliest next accept is the cycle after the rsp handshake.
- INIT_TLR takes 12·CLK_DIV clks after reset deasserts.

## Configuration
- JTAG_SCAN_TAP_RESET_EN defined: op 10 runs the INIT_TLR sequence (6 TCKs) and then responds with rsp_err=0 and rsp_data=0. cmd_len is ignored.
- JTAG_SCAN_TAP_RESET_EN undefined: op 10 is treated as reserved (rsp_err=1, no TCK). The post-reset INIT_TLR sequence is always present.

## Structure
- Package jtag_scan_pkg holds:
  - op encodings: OP_DR, OP_IR, OP_TLR, OP_RSVD;
  - the FSM state enum;
  - constants TLR_TCKS=5, DR_OVERHEAD=5, IR_OVERHEAD=6.
- Sub-module jtag_scan_tck_gen: CLK_DIV divider producing jtag_tck plus one-cycle fall_stb/rise_stb strobes and a TCK counter. Its load/run are controlled by the FSM.

## Test plan
- Reset release, CLK_DIV=4: 6 TCKs, TMS sequence 1,1,1,1,1,0; cmd_ready rises at cycle 48.
- DR scan, len=38, data 0x2A_5A5A_5A5A, TDO looped to TDI: 43 TCKs, rsp_data=0x2A_5A5A_5A5A, rsp_valid at E+344.
- IR scan, len=2, data 2'b10, TDO tied 1: TMS 1,1,0,0,0,1,1,0; TDI 0,0,0,0,0,1,0,0; rsp_data=0x3.
- len=0, then len=39: no TCK edges, rsp_err=1 at E+1; cmd_ready stays low until rsp_ready.
- rsp_ready held low 20 cycles: rsp_valid and rsp_data stable, cmd_ready=0. Reset asserted at TCK 10 of a DR scan: tck=0 next edge, INIT_TLR reruns.
- op 10: with JTAG_SCAN_TAP_RESET_EN, 6 TCKs and rsp_err=0; without it, zero TCKs and rsp_err=1.

Source files
------------

// File: rtl/jtag_scan_pkg.sv
// Shared encodings and TAP-walk constants for the JTAG scan master.
// Optional feature macro: JTAG_SCAN_TAP_RESET_EN (op 10 runs a TAP reset walk).
package jtag_scan_pkg;

  typedef enum logic [1:0] {
    OP_DR   = 2'b00,
    OP_IR   = 2'b01,
    OP_TLR  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    INIT_TLR,
    IDLE,
    SCAN,
    RESP
  } state_e;

  localparam int TLR_TCKS    = 5;
  localparam int DR_OVERHEAD = 5;
  localparam int IR_OVERHEAD = 6;

endpackage

// File: rtl/jtag_scan_tck_gen.sv
// TCK divider: CLK_DIV clks per half-period, strobes flag the edge on which TCK rises/falls.
// Load restarts a low phase with the TCK index at 0; the index advances on every fall.
module jtag_scan_tck_gen
  import jtag_scan_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CNT_W   = 6
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic             i_run,
  output logic             o_tck,
  output logic             o_fall_stb,
  output logic             o_rise_stb,
  output logic [CNT_W-1:0] o_tck_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div;
  logic             r_tck;
  logic [CNT_W-1:0] r_cnt;
  logic             w_toggle;

  assign w_toggle   = i_run && (r_div == DIV_LAST);
  assign o_rise_stb = w_toggle && !r_tck;
  assign o_fall_stb = w_toggle && r_tck;
  assign o_tck      = r_tck;
  assign o_tck_cnt  = r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_load) begin
      r_div <= '0;
      r_tck <= 1'b0;
      r_cnt <= '0;
    end else if (i_run) begin
      if (w_toggle) begin
        r_div <= '0;
        r_tck <= ~r_tck;
        if (r_tck) r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan engine: walks the TAP from Run-Test/Idle through IR/DR shifts and back.
// Define JTAG_SCAN_TAP_RESET_EN to let op 10 rerun the Test-Logic-Reset walk on demand.
module jtag_scan_master
  import jtag_scan_pkg::*;
#(
  parameter int DATA_W  = 38,
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              jtag_tck,
  output logic              jtag_tms,
  output logic              jtag_tdi,
  input  logic              jtag_tdo
);

  localparam int CNT_W = $clog2(DATA_W + IR_OVERHEAD + 1);

  // TMS for TCK k of a scan whose shift window is [pre, pre+len).
  function automatic logic scan_tms(input logic [CNT_W-1:0] k, input logic [CNT_W-1:0] pre,
                                    input logic [CNT_W-1:0] len);
    logic [CNT_W-1:0] sh_end;
    sh_end = pre + len;
    if (k < pre)                     scan_tms = (k < pre - CNT_W'(2));
    else if (k + CNT_W'(1) < sh_end) scan_tms = 1'b0;
    else                             scan_tms = (k <= sh_end);
  endfunction

  state_e            r_state;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_tms;
  logic              r_tdi;
  logic [DATA_W-1:0] r_sr;
  logic [DATA_W-1:0] r_mask;
  logic [CNT_W-1:0]  r_pre;
  logic [CNT_W-1:0]  r_len;
  logic [CNT_W-1:0]  r_last;
  logic              r_bad;
`ifdef JTAG_SCAN_TAP_RESET_EN
  logic              r_tlr_cmd;
`endif

  logic             w_fall;
  logic             w_rise;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_nxt;
  logic             w_cur_shift;
  logic             w_nxt_shift;
  logic             w_len_ok;
  logic             w_accept;
  logic             w_run;

  assign w_accept    = (r_state == IDLE) && cmd_valid && r_cmd_ready;
  assign w_run       = (r_state == INIT_TLR) || ((r_state == SCAN) && !r_bad);
  assign w_len_ok    = (cmd_len != '0) && (cmd_len <= LEN_W'(DATA_W));
  assign w_nxt       = w_cnt + CNT_W'(1);
  assign w_cur_shift = (w_cnt >= r_pre) && (w_cnt < r_pre + r_len);
  assign w_nxt_shift = (w_nxt >= r_pre) && (w_nxt < r_pre + r_len);

  jtag_scan_tck_gen #(
    .CLK_DIV (CLK_DIV),
    .CNT_W   (CNT_W)
  ) u_tck_gen (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (w_accept),
    .i_run      (w_run),
    .o_tck      (jtag_tck),
    .o_fall_stb (w_fall),
    .o_rise_stb (w_rise),
    .o_tck_cnt  (w_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= INIT_TLR;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
      r_tms       <= 1'b1;
      r_tdi       <= 1'b0;
      r_sr        <= '0;
      r_mask      <= '0;
      r_pre       <= '0;
      r_len       <= '0;
      r_last      <= '0;
      r_bad       <= 1'b0;
`ifdef JTAG_SCAN_TAP_RESET_EN
      r_tlr_cmd   <= 1'b0;
`endif
    end else begin
      case (r_state)
        INIT_TLR: begin
          if (w_fall) begin
            if (w_cnt == CNT_W'(TLR_TCKS)) begin
              r_tms <= 1'b0;
`ifdef JTAG_SCAN_TAP_RESET_EN
              if (r_tlr_cmd) begin
                r_tlr_cmd   <= 1'b0;
                r_state     <= RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b0;
              end else begin
                r_state     <= IDLE;
                r_cmd_ready <= 1'b1;
              end
`else
              r_state     <= IDLE;
              r_cmd_ready <= 1'b1;
`endif
            end else begin
              r_tms <= (w_nxt < CNT_W'(TLR_TCKS));
            end
          end
        end

        IDLE: begin
          if (w_accept) begin
            // Rejected commands also pass through SCAN so rsp_valid lands one edge later.
            r_cmd_ready <= 1'b0;
            r_rsp_data  <= '0;
            r_tdi       <= 1'b0;
            r_sr        <= cmd_data;
            r_mask      <= DATA_W'(1);
            r_len       <= CNT_W'(cmd_len);
            r_state     <= SCAN;
            r_bad       <= 1'b1;
            case (op_e'(cmd_op))
              OP_DR: if (w_len_ok) begin
                r_bad  <= 1'b0;
                r_tms  <= 1'b1;
                r_pre  <= CNT_W'(DR_OVERHEAD - 2);
                r_last <= CNT_W'(DR_OVERHEAD - 1) + CNT_W'(cmd_len);
              end
              OP_IR: if (w_len_ok) begin
                r_bad  <= 1'b0;
                r_tms  <= 1'b1;
                r_pre  <= CNT_W'(IR_OVERHEAD - 2);
                r_last <= CNT_W'(IR_OVERHEAD - 1) + CNT_W'(cmd_len);
              end
`ifdef JTAG_SCAN_TAP_RESET_EN
              OP_TLR: begin
                r_bad     <= 1'b0;
                r_tms     <= 1'b1;
                r_state   <= INIT_TLR;
                r_tlr_cmd <= 1'b1;
              end
`endif
              default: ;
            endcase
          end
        end

        SCAN: begin
          if (r_bad) begin
            r_bad       <= 1'b0;
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
          end else begin
            if (w_rise && w_cur_shift && jtag_tdo) r_rsp_data <= r_rsp_data | r_mask;
            if (w_fall) begin
              if (w_cnt == r_last) begin
                r_state     <= RESP;
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= 1'b0;
                r_tms       <= 1'b0;
                r_tdi       <= 1'b0;
              end else begin
                r_tms <= scan_tms(w_nxt, r_pre, r_len);
                if (w_cur_shift) begin
                  r_sr   <= r_sr >> 1;
                  r_mask <= r_mask << 1;
                end
                r_tdi <= w_nxt_shift ? (w_cur_shift ? r_sr[1] : r_sr[0]) : 1'b0;
              end
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_cmd_ready <= 1'b1;
          end
        end

        default: r_state <= INIT_TLR;
      endcase
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_data  = r_rsp_data;
  assign jtag_tms  = r_tms;
  assign jtag_tdi  = r_tdi;

endmodule
